// File: rtl/mant_div_pkg.sv
// ---------------------------------------------------------------------------
// mant_div_pkg
// Shared constants for the mantissa divider: the default operand width,
// the IDLE/CALC/DONE state encoding and the iteration counter width.
// ---------------------------------------------------------------------------
package mant_div_pkg;

    localparam int DEF_WIDTH = 24;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    // The counter must be able to represent 0..w, so it is sized from w+1.
    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_CNT_W = cntWidth(DEF_WIDTH);

endpackage

// File: rtl/mant_div_sub.sv
// ---------------------------------------------------------------------------
// mant_div_sub
// Ripple-carry subtractor used for the trial subtraction of the divider.
// difference = minuend - subtrahend (modulo 2^N), borrow = minuend < subtrahend.
//
// Ports:
//   minuend     in  N   value subtracted from
//   subtrahend  in  N   value being subtracted
//   difference  out N   minuend - subtrahend
//   borrow      out 1   high when the subtraction underflows
// ---------------------------------------------------------------------------
module mant_div_sub #(
    parameter int N = 25
) (
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic [N-1:0] difference,
    output logic         borrow
);

    logic [N-1:0] subInv;
    logic [N:0]   carry;

    // Two's complement subtraction: add the inverted subtrahend with a
    // carry-in of one. A missing carry-out means the result borrowed.
    assign subInv   = ~subtrahend;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : gFullAdd
        assign difference[i] = minuend[i] ^ subInv[i] ^ carry[i];
        assign carry[i+1]    = (minuend[i] & subInv[i]) | (carry[i] & (minuend[i] ^ subInv[i]));
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/mant_div24.sv
// ---------------------------------------------------------------------------
// mant_div24
// Multi-cycle unsigned restoring divider for floating-point mantissas.
// One quotient bit is produced per clock; a division takes WIDTH cycles in
// CALC followed by one DONE cycle. Division by zero finishes immediately
// with q = all ones, r = a and div_by_zero set.
//
// Optional feature: define MANT_DIV_STICKY_EN to register a sticky bit
// (final remainder nonzero) alongside the result. Without it the sticky
// port is tied low.
//
// Ports:
//   clk          in  1      clock, rising edge
//   rst          in  1      synchronous active-high reset
//   start        in  1      request a division (sampled in IDLE only)
//   a            in  WIDTH  dividend
//   b            in  WIDTH  divisor
//   busy         out 1      state is not IDLE
//   done         out 1      one-cycle result-valid pulse
//   q            out WIDTH  quotient
//   r            out WIDTH  remainder
//   div_by_zero  out 1      last result came from b == 0
//   sticky       out 1      last remainder nonzero (rounding aid)
// ---------------------------------------------------------------------------
module mant_div24
    import mant_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             sticky
);

    localparam int                 CNT_W    = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH:0]   rem_q,   rem_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] div_q,   div_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] rmd_q,   rmd_d;
    logic             dbz_q,   dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] dvdNext;
    logic             lastIter;
    logic             unusedRemMsb;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and try to subtract the divisor. The remainder stays below
    // the divisor, so its top bit is always zero before the shift and the
    // shifted value fits in WIDTH+1 bits.
    assign trial = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

    mant_div_sub #(.N(WIDTH + 1)) u_sub (
        .minuend    (trial),
        .subtrahend ({1'b0, div_q}),
        .difference (diff),
        .borrow     (borrow)
    );

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign remNext      = borrow ? trial : diff;
    assign dvdNext      = {dvd_q[WIDTH-2:0], ~borrow};
    assign lastIter     = (state_q == STATE_CALC) && (cnt_q == LAST_CNT);
    assign unusedRemMsb = rem_q[WIDTH] ^ remNext[WIDTH];

    // Next-state logic for the FSM, datapath and result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        quo_d   = '1;
                        rmd_d   = a;
                        dbz_d   = 1'b1;
                        state_d = STATE_DONE;
                    end else begin
                        dvd_d   = a;
                        div_d   = b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = STATE_CALC;
                    end
                end
            end
            STATE_CALC: begin
                rem_d = remNext;
                dvd_d = dvdNext;
                cnt_d = cnt_q + 1'b1;
                if (lastIter) begin
                    quo_d   = dvdNext;
                    rmd_d   = remNext[WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef MANT_DIV_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky follows the remainder that is published with the result; for
    // a divide-by-zero the published remainder is the dividend itself.
    always_comb begin
        sticky_d = sticky_q;
        if ((state_q == STATE_IDLE) && start && (b == '0)) begin
            sticky_d = (a != '0);
        end else if (lastIter) begin
            sticky_d = (remNext[WIDTH-1:0] != '0);
        end
    end

    // Sticky register, cleared with the rest of the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign busy        = (state_q != STATE_IDLE);
    assign done        = (state_q == STATE_DONE);
    assign q           = quo_q;
    assign r           = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mant_div24.sv
// ---------------------------------------------------------------------------
// tb_mant_div24
// Directed scoreboard bench for mant_div24 (WIDTH = 24). Expected results
// come from a behavioural divide model and are queued when a start is
// accepted, then popped when done is seen.
// ---------------------------------------------------------------------------
module tb_mant_div24;

    localparam int W = 24;

`ifdef MANT_DIV_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         sticky;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;
    logic         sticky;

    int   checks;
    int   failures;
    exp_t sb[$];

    mant_div24 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero),
        .sticky      (sticky)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model of an unsigned divider, independent of the RTL.
    function automatic exp_t model(input logic [W-1:0] da, input logic [W-1:0] db);
        exp_t e;
        if (db == '0) begin
            e.q   = '1;
            e.r   = da;
            e.dbz = 1'b1;
        end else begin
            e.q   = da / db;
            e.r   = da % db;
            e.dbz = 1'b0;
        end
        e.sticky = STICKY_ON && (e.r != '0);
        return e;
    endfunction

    // Single comparison point with counting and failure report.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one request in IDLE; returns just after the acceptance edge.
    task automatic applyStimulus(input logic [W-1:0] da, input logic [W-1:0] db, input bit push);
        start = 1'b1;
        a     = da;
        b     = db;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb.push_back(model(da, db));
    endtask

    // Wait a bounded number of edges for done, then score the result and
    // confirm the pulse is exactly one cycle wide.
    task automatic waitDone(input int expLat, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'(expLat));
        if (sb.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_q"},      64'(q),           64'(e.q));
            checkOutput({tag, "_r"},      64'(r),           64'(e.r));
            checkOutput({tag, "_dbz"},    64'(div_by_zero), 64'(e.dbz));
            checkOutput({tag, "_sticky"}, 64'(sticky),      64'(e.sticky));
        end
        checkOutput({tag, "_busyDone"}, 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_busyIdle"},  64'(busy), 64'(0));
    endtask

    // Count done pulses over a window where none should appear.
    task automatic expectQuiet(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checkOutput({tag, "_noDone"}, 64'(pulses), 64'(0));
    endtask

    // Directed sequence.
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy",   64'(busy),        64'(0));
        checkOutput("rst_done",   64'(done),        64'(0));
        checkOutput("rst_q",      64'(q),           64'(0));
        checkOutput("rst_r",      64'(r),           64'(0));
        checkOutput("rst_dbz",    64'(div_by_zero), 64'(0));
        checkOutput("rst_sticky", 64'(sticky),      64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] power-of-two dividend");
        applyStimulus(24'h800000, 24'h000002, 1'b1);
        checkOutput("pow2_busyCalc", 64'(busy), 64'(1));
        waitDone(24, "pow2");

        $display("[TB] exact thirds and small odd quotient");
        applyStimulus(24'hFFFFFF, 24'h000003, 1'b1);
        waitDone(24, "thirds");
        applyStimulus(24'h000007, 24'h000002, 1'b1);
        waitDone(24, "sevenHalves");

        $display("[TB] divide by zero then a < b");
        applyStimulus(24'h123456, 24'h000000, 1'b1);
        waitDone(0, "divZero");
        applyStimulus(24'h000005, 24'h000009, 1'b1);
        waitDone(24, "aLessB");

        $display("[TB] start ignored while busy");
        applyStimulus(24'd100, 24'd7, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 24'd9;
        b     = 24'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ignore_busyStill", 64'(busy), 64'(1));
        waitDone(14, "ignore");
        expectQuiet(30, "ignore");

        $display("[TB] reset in the middle of CALC");
        applyStimulus(24'd1000, 24'd3, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midRst_busy",   64'(busy),        64'(0));
        checkOutput("midRst_done",   64'(done),        64'(0));
        checkOutput("midRst_q",      64'(q),           64'(0));
        checkOutput("midRst_r",      64'(r),           64'(0));
        checkOutput("midRst_dbz",    64'(div_by_zero), 64'(0));
        checkOutput("midRst_sticky", 64'(sticky),      64'(0));
        expectQuiet(30, "midRst");
        applyStimulus(24'd50, 24'd5, 1'b1);
        waitDone(24, "afterRst");

        checkOutput("sb_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
